// File: rtl/pipe_hazard_ctrl.sv
// Purpose : hazard/stall controller for an in-order pipeline (bubbles, register write enables, PC write).
// Latency : stage controls are combinational from inputs and current state; state/counters update on clock.
// Backpress: mem_ready=0 freezes every stage and the PC; divide and trap drains hold the front end.
module pipe_hazard_ctrl #(
  parameter int NSTAGES = 5,
  parameter int REGW    = 5,
  parameter int DIV_LAT = 32,
  parameter int CNTW    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_ready,
  input  logic                 instr_stall,
  input  logic [REGW-1:0]      ifid_rs,
  input  logic [REGW-1:0]      ifid_rt,
  input  logic [REGW-1:0]      idex_rd,
  input  logic                 idex_memread,
  input  logic                 idex_memwrite,
  input  logic                 ifid_memread,
  input  logic                 jump,
  input  logic                 trap_in_id,
  input  logic                 branch_pending,
  input  logic                 pcsrc,
  input  logic                 syscall,
  input  logic                 int_trap,
  input  logic                 flush,
  input  logic                 div_start,
  output logic [NSTAGES-2:0]   bubble,
  output logic [NSTAGES-2:0]   write,
  output logic                 write_pc,
  output logic                 trap_waiting,
  output logic [2:0]           state,
  output logic [CNTW-1:0]      stall_count
);

  localparam int W = NSTAGES - 1;

  // Taken branch squashes the three youngest pipeline registers.
  localparam logic [W-1:0] PCSRC_BUBBLE = W'(7);
  // During a divide only ID/EX keeps loading (the divider owns EX).
  localparam logic [W-1:0] DIV_WRITE    = W'(2);
  // Counter runs DIV_LAT-1 down to 0 inclusive, giving DIV_LAT busy cycles.
  localparam logic [7:0]   DIV_LOAD     = 8'(DIV_LAT - 1);

  typedef enum logic [2:0] {
    S_RUN       = 3'd0,
    S_MEMWAIT   = 3'd1,
    S_DIVBUSY   = 3'd2,
    S_TRAPDRAIN = 3'd3
  } state_t;

  state_t     state_q, state_d;
  state_t     saved_q, saved_d;
  state_t     eff_state;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic       trap_pending_q, trap_pending_d;
  logic       id_hazard;
  logic       hold_id;

  // Structural conflict on the single data port, or a load feeding the very next instruction.
  assign id_hazard = (ifid_memread & idex_memwrite) |
                     (idex_memread & (idex_rd != '0) &
                      ((idex_rd == ifid_rs) | (idex_rd == ifid_rt)));

  assign state = state_q;

  // Per-stage controls and next state, evaluated highest-priority event first.
  always_comb begin
    // While waiting on memory the machine behaves as the state it left once memory is ready.
    eff_state      = (state_q == S_MEMWAIT) ? saved_q : state_q;
    state_d        = eff_state;
    saved_d        = saved_q;
    div_cnt_d      = div_cnt_q;
    trap_pending_d = trap_pending_q;
    bubble         = '0;
    write          = '1;
    write_pc       = 1'b1;
    trap_waiting   = 1'b0;
    hold_id        = 1'b0;

    if (int_trap) begin
      bubble         = '1;
      state_d        = S_RUN;
      div_cnt_d      = '0;
      trap_pending_d = 1'b0;
    end else if (pcsrc) begin
      // A pending syscall was on the wrong path, so it is dropped.
      bubble         = PCSRC_BUBBLE;
      state_d        = S_RUN;
      div_cnt_d      = '0;
      trap_pending_d = 1'b0;
    end else if (!mem_ready) begin
      write    = '0;
      write_pc = 1'b0;
      state_d  = S_MEMWAIT;
      if (state_q != S_MEMWAIT) begin
        saved_d = state_q;
      end
    end else if (eff_state == S_DIVBUSY) begin
      write    = DIV_WRITE;
      write_pc = 1'b0;
      if (div_cnt_q == '0) begin
        state_d = S_RUN;
      end else begin
        div_cnt_d = div_cnt_q - 1'b1;
      end
    end else if (eff_state == S_TRAPDRAIN) begin
      if (branch_pending) begin
        hold_id = 1'b1;
      end else begin
        trap_waiting   = trap_pending_q;
        trap_pending_d = 1'b0;
        state_d        = S_RUN;
      end
    end else begin
      hold_id = id_hazard;
      if (div_start) begin
        div_cnt_d = DIV_LOAD;
        state_d   = S_DIVBUSY;
      end else if (syscall && branch_pending) begin
        trap_pending_d = 1'b1;
        state_d        = S_TRAPDRAIN;
        hold_id        = 1'b1;
      end else if (syscall && !id_hazard) begin
        trap_waiting = 1'b1;
      end
      if (!hold_id && ((jump && !instr_stall) || trap_in_id)) begin
        bubble[0] = 1'b1;
      end
    end

    if (hold_id) begin
      bubble[1] = 1'b1;
      write[0]  = 1'b0;
      write_pc  = 1'b0;
    end

    // Fetch stall holds the PC unless a redirect (trap or taken branch) must win.
    if (!int_trap && !pcsrc && instr_stall) begin
      write_pc = 1'b0;
      if (jump) begin
        write[0] = 1'b0;
      end
    end

    if (flush) begin
      bubble[0] = 1'b1;
    end

    if (!reset) begin
      bubble       = '1;
      write        = '0;
      write_pc     = 1'b0;
      trap_waiting = 1'b0;
    end
  end

  // State register, divide counter, trap bookkeeping and saturating stall counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_RUN;
      saved_q        <= S_RUN;
      div_cnt_q      <= '0;
      trap_pending_q <= 1'b0;
      stall_count    <= '0;
    end else begin
      state_q        <= state_d;
      saved_q        <= saved_d;
      div_cnt_q      <= div_cnt_d;
      trap_pending_q <= trap_pending_d;
      if (!write_pc && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NSTAGES, default 5: pipeline depth; NSTAGES-1 pipeline registers, index 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB (generalises).
REQ-002 Parameter REGW, default 5: register-index width.
REQ-003 Parameter DIV_LAT, default 32: multicycle-divide stall length in cycles, legal range 2..255.
REQ-004 Parameter CNTW, default 16: stall-counter width.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 Ports: clock in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-007 Ports: mem_ready in 1 data memory ready; instr_stall in 1 instruction fetch stall.
REQ-008 Ports: ifid_rs, ifid_rt in REGW ID sources; idex_rd in REGW EX destination; idex_memread, idex_memwrite in 1 EX load/store; ifid_memread in 1 ID load.
REQ-009 Ports: jump in 1 jump in ID; trap_in_id in 1 trap instruction in ID; branch_pending in 1 branch in ID/EX or EX/MEM; pcsrc in 1 taken branch in MEM.
REQ-010 Ports: syscall in 1; int_trap in 1 interrupt/exception; flush in 1 external IF/ID flush; div_start in 1 divide issued from EX.
REQ-011 Ports: bubble out NSTAGES-1; write out NSTAGES-1; write_pc out 1; trap_waiting out 1; state out 3; stall_count out CNTW.

Function
REQ-012 FSM states: RUN=0, MEMWAIT=1, DIVBUSY=2, TRAPDRAIN=3; state output equals the current state register.
REQ-013 Defaults each cycle: bubble all 0, write all 1, write_pc 1, trap_waiting 0.
REQ-014 Combinational priority, highest first: int_trap, pcsrc, mem_ready=0, DIVBUSY, TRAPDRAIN, ifid_memread & idex_memwrite, load-use, jump/trap_in_id.
REQ-015 int_trap=1: bubble all 1, write_pc 1; next state RUN; divide counter and trap_pending cleared.
REQ-016 pcsrc=1: bubble[2:0]=1, write_pc 1; trap_pending cleared (squashed wrong-path syscall); next state RUN.
REQ-017 mem_ready=0: write all 0, write_pc 0; next state MEMWAIT; divide counter frozen; previous state saved and restored when mem_ready returns to 1.
REQ-018 div_start=1 in RUN, no higher event: counter loads DIV_LAT-1, next state DIVBUSY.
REQ-019 DIVBUSY: write all 0 except write[1]=1, write_pc 0; counter decrements per cycle; at counter 0 next state RUN; total stall exactly DIV_LAT cycles.
REQ-020 syscall=1 with branch_pending=1 in RUN: trap_pending set, bubble[1]=1, write[0]=0, write_pc 0; next state TRAPDRAIN.
REQ-021 TRAPDRAIN: same holds as REQ-020 while branch_pending=1; when branch_pending=0, trap_waiting=1 for exactly one cycle, trap_pending cleared, next state RUN.
REQ-022 syscall=1 with branch_pending=0 in RUN, no stall: trap_waiting=1 same cycle.
REQ-023 Structural conflict (ifid_memread & idex_memwrite) or load-use (idex_memread & idex_rd!=0 & idex_rd equals ifid_rs or ifid_rt): bubble[1]=1, write[0]=0, write_pc 0.
REQ-024 jump=1 & instr_stall=0, or trap_in_id=1: bubble[0]=1.
REQ-025 instr_stall=1: write_pc 0 (overrides REQ-015/016 only when int_trap and pcsrc are 0); with jump=1 also write[0]=0.
REQ-026 flush=1: bubble[0]=1 OR-ed onto any result.
REQ-027 stall_count increments every cycle write_pc=0, saturates at all-ones, never wraps.

Reset
REQ-028 reset=0 asynchronously: state RUN, counter 0, trap_pending 0, stall_count 0.
REQ-029 While reset=0: bubble all 1, write all 0, write_pc 0, trap_waiting 0; normal operation from first clock edge after release.

Verification
REQ-030 div_start pulse, DIV_LAT=32 -> write_pc=0 for exactly 32 cycles, state 2 throughout, then RUN; stall_count=32.
REQ-031 syscall with branch_pending=1 for 3 cycles -> TRAPDRAIN 3 cycles, then trap_waiting=1 one cycle; with pcsrc=1 on cycle 2 instead -> trap_waiting never asserts.
REQ-032 mem_ready=0 for 4 cycles mid-DIVBUSY -> all writes 0, divide stall extends by exactly 4 cycles, DIVBUSY resumes.
REQ-033 idex_memread=1, idex_rd=7, ifid_rt=7 -> bubble=4'b0010, write=4'b1110, write_pc=0; idex_rd=0 -> no stall.
REQ-034 int_trap during DIVBUSY -> bubble=4'b1111, next state RUN, counter 0.
REQ-035 reset asserted mid-TRAPDRAIN -> state 0, trap_pending 0 immediately, no trap_waiting after release.
